// File: rtl/bcd_result_display.sv
// Captures the BCD subtractor result, converts a borrowed result to its magnitude
// one digit per cycle, and drives a multiplexed common-anode 7-segment display.
module bcd_result_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] diff,
  input  logic        bout,
  output logic [15:0] mag,
  output logic        neg,
  output logic        ready,
  output logic        err,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  k;
  logic        c;
  logic [15:0] cap_diff;
  logic        cap_bout;
  logic        cap_err;
  logic [15:0] work;

  logic        in_err;
  logic [3:0]  d_cur;
  logic [4:0]  t;
  logic [3:0]  r_dig;
  logic        c_nxt;
  logic [15:0] work_nxt;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    sel_dig;
  logic          lead_zero;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    in_err = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (diff[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // Serial ten's-complement: each digit is 0 - d - borrow, folded back into 0..9.
  always_comb begin
    d_cur    = cap_diff[{k, 2'b00} +: 4];
    t        = 5'd0 - {1'b0, d_cur} - {4'b0000, c};
    r_dig    = d_cur;
    c_nxt    = c;
    if (cap_bout) begin
      if (t[4]) begin
        r_dig = t[3:0] + 4'd10;
        c_nxt = 1'b1;
      end else begin
        r_dig = t[3:0];
        c_nxt = 1'b0;
      end
    end
    work_nxt                  = work;
    work_nxt[{k, 2'b00} +: 4] = r_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      c        <= 1'b0;
      cap_diff <= '0;
      cap_bout <= 1'b0;
      cap_err  <= 1'b0;
      work     <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else if (load) begin
      // A load in any state, including mid-conversion, restarts from digit 0.
      cap_diff <= diff;
      cap_bout <= bout;
      cap_err  <= in_err;
      k        <= '0;
      c        <= 1'b0;
      ready    <= 1'b0;
      state    <= CONV;
    end else begin
      case (state)
        CONV: begin
          work <= work_nxt;
          c    <= c_nxt;
          k    <= k + 2'd1;
          if (k == 2'd3) begin
            mag   <= work_nxt;
            neg   <= cap_bout;
            err   <= cap_err;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    sel_dig = mag[{idx, 2'b00} +: 4];
    case (idx)
      2'd1:    lead_zero = (mag[15:4] == 12'h000);
      2'd2:    lead_zero = (mag[15:8] == 8'h00);
      2'd3:    lead_zero = (mag[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
    if (err)
      seg_nxt = SEG_DASH;
    else if (BLANK_LZ && lead_zero)
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = seg_of(sel_dig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_nxt;
    end
  end

endmodule
